instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 13 +
 rtl/instr_fetch_if.sv | 27 ++
 rtl/endian_swap.sv | 10 +
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types: fetch FSM states and bus byte-enable constants.
// No ports; imported by the fetch unit.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fetch_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/instr_fetch_if.sv
// Word-read memory bus: address/read/byteenable out, waitrequest/readdata in.
// master = requester (fetch unit), slave = memory side.
interface instr_fetch_if;

  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output byteenable,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  byteenable,
    output waitrequest,
    output readdata
  );

endinterface

// File: rtl/endian_swap.sv
// Combinational byte-lane reversal of a 32-bit word.
// Ports: din (word in), dout (bytes reversed).
module endian_swap (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one bus word read per request, byte-swapped into memdata.
// Ports: clk, reset, fetch_req, pc, bus (master), memdata, IRWrite, busy, fault.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_req,
  input  logic [31:0]  pc,
  instr_fetch_if.master bus,
  output logic [31:0]  memdata,
  output logic         IRWrite,
  output logic         busy,
  output logic         fault
);

  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  fetch_state_t  state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          read_q, read_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   mem_q, mem_d;
  logic          irw_q, irw_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   swapped;
  logic          aligned;

  endian_swap u_swap (
    .din  (bus.readdata),
    .dout (swapped)
  );

  assign aligned = (pc[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    read_d  = read_q;
    be_d    = be_q;
    mem_d   = mem_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    irw_d   = 1'b0;
    fault_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (fetch_req && aligned) begin
          state_d = REQ;
          addr_d  = pc;
          read_d  = 1'b1;
          be_d    = BE_WORD;
          busy_d  = 1'b1;
          wcnt_d  = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          fault_d = fetch_req;
        end
      end
      REQ: begin
        // completion is checked first so it wins over a same-edge timeout
        if (!bus.waitrequest) begin
          state_d = DONE;
          mem_d   = swapped;
          read_d  = 1'b0;
          be_d    = '0;
          irw_d   = 1'b1;
        end else if (wcnt_q >= TMO) begin
          state_d = IDLE;
          read_d  = 1'b0;
          be_d    = '0;
          busy_d  = 1'b0;
          fault_d = 1'b1;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        be_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      be_q    <= '0;
      mem_q   <= '0;
      irw_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      be_q    <= be_d;
      mem_q   <= mem_d;
      irw_q   <= irw_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.read       = read_q;
  assign bus.byteenable = be_q;
  assign memdata        = mem_q;
  assign IRWrite        = irw_q;
  assign busy           = busy_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic
// against a transaction-level model of the fetch rules.
module tb_instr_fetch;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] memdata;
  logic        IRWrite;
  logic        busy;
  logic        fault;

  instr_fetch_if bus ();

  instr_fetch #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_req (fetch_req),
    .pc        (pc),
    .bus       (bus),
    .memdata   (memdata),
    .IRWrite   (IRWrite),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: at most one outstanding read; it either completes,
  // times out after T tolerated stall cycles, or keeps stalling.
  logic [31:0] m_addr = '0;
  logic [31:0] m_mem = '0;
  logic [3:0]  m_be = '0;
  bit          m_read = 0;
  bit          m_irw = 0;
  bit          m_fault = 0;
  bit          m_busy = 0;
  int          m_waits = 0;

  always @(posedge clk) begin
    logic fr;
    logic wr;
    logic [31:0] p;
    logic [31:0] rd;
    fr = fetch_req;
    wr = bus.waitrequest;
    p  = pc;
    rd = bus.readdata;
    m_irw = 0;
    m_fault = 0;
    if (reset) begin
      m_addr = '0;
      m_mem = '0;
      m_be = '0;
      m_read = 0;
      m_busy = 0;
      m_waits = 0;
    end else if (m_read) begin
      if (!wr) begin
        m_mem = {<<8{rd}};
        m_read = 0;
        m_be = '0;
        m_irw = 1;
      end else if (m_waits >= T) begin
        m_read = 0;
        m_be = '0;
        m_fault = 1;
        m_busy = 0;
      end else begin
        m_waits++;
      end
    end else if (fr && p[1:0] == 2'b00) begin
      m_addr = p;
      m_read = 1;
      m_be = 4'hF;
      m_busy = 1;
      m_waits = 0;
    end else begin
      m_busy = 0;
      m_fault = fr;
    end
    #1;
    if (chk_en) begin
      chk("address", bus.address, m_addr);
      chk("read", 32'(bus.read), 32'(m_read));
      chk("byteenable", 32'(bus.byteenable), 32'(m_be));
      chk("memdata", memdata, m_mem);
      chk("IRWrite", 32'(IRWrite), 32'(m_irw));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("irw_fault_excl", 32'(IRWrite & fault), 32'd0);
    end
  end

  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d,
                           input int nwait, output int rdc, output int irw,
                           output int irw_at, output int flt,
                           output int bsy, output int addr_bad);
    rdc = 0; irw = 0; irw_at = -1; flt = 0; bsy = 0; addr_bad = 0;
    @(negedge clk);
    fetch_req = 1'b1;
    pc = a;
    bus.waitrequest = 1'b0;
    bus.readdata = d;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      if (bus.read) begin
        rdc++;
        if (bus.address !== a) addr_bad++;
      end
      if (IRWrite) begin
        irw++;
        if (irw_at < 0) irw_at = i;
      end
      if (fault) flt++;
      if (busy) bsy++;
      bus.waitrequest = bus.read && (rdc <= nwait);
    end
    bus.waitrequest = 1'b0;
  endtask

  int rdc, irw, irw_at, flt, bsy, abad;
  logic [31:0] seq_mem [3];
  int nseq;
  int stall;
  logic [31:0] tmp;

  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_address", bus.address, 32'h0);
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_be", 32'(bus.byteenable), 32'd0);
    chk("rst_memdata", memdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irw", 32'(IRWrite), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk_en = 1;
    reset = 1'b0;

    fetch_one(32'hBFC00000, 32'h78563412, 0, rdc, irw, irw_at, flt, bsy, abad);
    chk("zw_read_cycles", 32'(rdc), 32'd1);
    chk("zw_irw_count", 32'(irw), 32'd1);
    chk("zw_irw_cycle", 32'(irw_at), 32'd1);
    chk("zw_addr", 32'(abad), 32'd0);
    chk("zw_memdata", memdata, 32'h12345678);

    fetch_one(32'hBFC00000, 32'hA1B2C3D4, 3, rdc, irw, irw_at, flt, bsy, abad);
    chk("ws_read_cycles", 32'(rdc), 32'd4);
    chk("ws_irw_count", 32'(irw), 32'd1);
    chk("ws_irw_cycle", 32'(irw_at), 32'd4);
    chk("ws_addr", 32'(abad), 32'd0);
    chk("ws_memdata", memdata, 32'hD4C3B2A1);

    fetch_one(32'hBFC00002, 32'h0, 0, rdc, irw, irw_at, flt, bsy, abad);
    chk("mis_read_cycles", 32'(rdc), 32'd0);
    chk("mis_fault", 32'(flt), 32'd1);
    chk("mis_busy", 32'(bsy), 32'd0);
    chk("mis_irw", 32'(irw), 32'd0);

    fetch_one(32'h00001000, 32'hDEADBEEF, 100, rdc, irw, irw_at, flt, bsy, abad);
    chk("tmo_read_cycles", 32'(rdc), 32'd5);
    chk("tmo_fault", 32'(flt), 32'd1);
    chk("tmo_irw", 32'(irw), 32'd0);
    chk("tmo_memdata", memdata, 32'hD4C3B2A1);

    @(negedge clk);
    fetch_req = 1'b1;
    pc = 32'h0;
    bus.waitrequest = 1'b0;
    nseq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_read", 32'(bus.read), 32'(i % 2 == 0));
      chk("b2b_irw", 32'(IRWrite), 32'(i % 2 == 1));
      if (bus.read) chk("b2b_addr", bus.address, 32'(4 * (i / 2)));
      if (IRWrite && nseq < 3) begin
        seq_mem[nseq] = memdata;
        nseq++;
      end
      bus.readdata = 32'hC0DE0000 | bus.address;
      pc = 32'(4 * ((i + 1) / 2));
    end
    fetch_req = 1'b0;
    chk("b2b_count", 32'(nseq), 32'd3);
    chk("b2b_mem0", seq_mem[0], 32'h0000DEC0);
    chk("b2b_mem1", seq_mem[1], 32'h0400DEC0);
    chk("b2b_mem2", seq_mem[2], 32'h0800DEC0);
    repeat (3) @(negedge clk);

    @(negedge clk);
    fetch_req = 1'b1;
    pc = 32'h100;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("rr_read_before", 32'(bus.read), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rr_read_now", 32'(bus.read), 32'd0);
    chk("rr_memdata_now", memdata, 32'h0);
    chk("rr_busy_now", 32'(busy), 32'd0);
    bus.readdata = 32'hFFFFFFFF;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_irw", 32'(IRWrite), 32'd0);
      chk("rr_memdata", memdata, 32'h0);
      chk("rr_read", 32'(bus.read), 32'd0);
    end

    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      fetch_req = ($urandom_range(0, 2) != 0);
      tmp = $urandom;
      pc = ($urandom_range(0, 7) == 0) ? tmp : {tmp[31:2], 2'b00};
      if (stall == 0 && $urandom_range(0, 39) == 0)
        stall = $urandom_range(3, 8);
      if (stall > 0) begin
        bus.waitrequest = 1'b1;
        stall--;
      end else begin
        bus.waitrequest = ($urandom_range(0, 3) == 0);
      end
      bus.readdata = $urandom;
    end
    @(negedge clk);
    reset = 1'b0;
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
